// File: rtl/multicycle_decoder.sv
// Sequenced MIPS control decoder: latches one instruction per handshake,
// stalls for multi-cycle MULT and FPU add/sub, and traps on illegal codes.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   instr_valid/ready     instruction handshake; opcode/functcode/fmt in
//   zero                  ALU zero flag (branch resolve in EXEC)
//   fpu_done / fpu_start  FPU completion pulse in / launch pulse out
//   stall, illegal        core stall, sticky trap flag
//   remaining outputs     datapath control set decoded from the IR
module multicycle_decoder #(
  parameter int MULT_CYCLES = 4,
  parameter int ALUOP_W     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [5:0]         opcode,
  input  logic [5:0]         functcode,
  input  logic [4:0]         fmt,
  input  logic               zero,
  input  logic               fpu_done,
  output logic               fpu_start,
  output logic               stall,
  output logic               illegal,
  output logic               regWrite,
  output logic               muxA_en,
  output logic               dm_we,
  output logic               multiplyEn,
  output logic               dmDataSelect,
  output logic [1:0]         muxB_en,
  output logic [1:0]         regWriteAddSelect,
  output logic [1:0]         muxPC,
  output logic [1:0]         muxWD3_en,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               floatWriteAddrSelect,
  output logic               floatRegWrite,
  output logic               floatRWSelect
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MWAIT,
    S_FWAIT,
    S_FWB,
    S_TRAP
  } state_t;

  localparam logic [5:0] OP_RT   = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_XORI = 6'h0e;
  localparam logic [5:0] OP_FR   = 6'h11;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] OP_LWC1 = 6'h31;
  localparam logic [5:0] OP_SWC1 = 6'h39;

  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SLT  = 6'h2a;

  localparam logic [4:0] FMT_S = 5'h10;

  localparam logic [ALUOP_W-1:0] A_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] A_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] A_XOR = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] A_SLT = ALUOP_W'(3);

  // A one-cycle multiply behaves exactly like any single-cycle op.
  localparam logic MULT_MC = (MULT_CYCLES > 1);

  state_t      r_state;
  logic [16:0] r_ir;
  logic [7:0]  r_cnt;
  logic        r_illegal;

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_fmt;
  logic        w_legal;
  logic        w_mult;
  logic        w_fr;
  logic        w_multi;
  logic        w_accept;
  logic [ALUOP_W-1:0] w_fpu_op;

  assign w_op  = r_ir[16:11];
  assign w_fn  = r_ir[10:5];
  assign w_fmt = r_ir[4:0];

  always_comb begin
    w_legal = 1'b1;
    w_mult  = 1'b0;
    w_fr    = 1'b0;
    unique case (w_op)
      OP_RT: begin
        unique case (w_fn)
          F_JR, F_MFHI, F_MFLO,
          F_ADD, F_SUB, F_SLT: w_legal = 1'b1;
          F_MULT:              w_mult  = 1'b1;
          default:             w_legal = 1'b0;
        endcase
      end
      OP_FR: begin
        w_fr    = 1'b1;
        w_legal = (w_fmt == FMT_S) && (w_fn[5:1] == 5'd0);
      end
      OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_XORI,
      OP_LW, OP_SW, OP_LWC1, OP_SWC1: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_multi  = w_fr || (w_mult && MULT_MC);
  assign w_fpu_op = w_fn[0] ? A_SUB : A_ADD;

  // Only a legal single-cycle op in EXEC frees the slot for the next issue.
  assign instr_ready = (r_state == S_IDLE) ||
                       ((r_state == S_EXEC) && w_legal && !w_multi);
  assign w_accept    = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ir      <= '0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_accept) r_ir <= {opcode, functcode, fmt};
      unique case (r_state)
        S_IDLE: begin
          if (instr_valid) r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (!w_legal) begin
            r_state   <= S_TRAP;
            r_illegal <= 1'b1;
          end else if (w_fr) begin
            r_state <= S_FWAIT;
          end else if (w_mult && MULT_MC) begin
            r_state <= S_MWAIT;
            r_cnt   <= 8'(MULT_CYCLES - 2);
          end else begin
            r_state <= instr_valid ? S_EXEC : S_IDLE;
          end
        end
        S_MWAIT: begin
          if (r_cnt == 8'd0) r_state <= S_IDLE;
          else               r_cnt   <= r_cnt - 8'd1;
        end
        S_FWAIT: begin
          if (fpu_done) r_state <= S_FWB;
        end
        S_FWB:   r_state <= S_IDLE;
        S_TRAP:  r_state <= S_TRAP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall   = (r_state == S_MWAIT) || (r_state == S_FWAIT) ||
                   (r_state == S_FWB)   || (r_state == S_TRAP);
  assign illegal = r_illegal;

  always_comb begin
    regWrite             = 1'b0;
    muxA_en              = 1'b0;
    dm_we                = 1'b0;
    multiplyEn           = 1'b0;
    dmDataSelect         = 1'b0;
    muxB_en              = 2'd0;
    regWriteAddSelect    = 2'd0;
    muxPC                = 2'd0;
    muxWD3_en            = 2'd0;
    ALUop                = A_ADD;
    floatWriteAddrSelect = 1'b0;
    floatRegWrite        = 1'b0;
    floatRWSelect        = 1'b0;
    fpu_start            = 1'b0;
    if ((r_state == S_EXEC) && w_legal) begin
      unique case (w_op)
        OP_RT: begin
          muxB_en           = 2'd1;
          regWriteAddSelect = 2'd2;
          unique case (w_fn)
            F_ADD: begin
              regWrite  = 1'b1;
              muxWD3_en = 2'd1;
              ALUop     = A_ADD;
            end
            F_SUB: begin
              regWrite  = 1'b1;
              muxWD3_en = 2'd1;
              ALUop     = A_SUB;
            end
            F_SLT: begin
              regWrite  = 1'b1;
              muxWD3_en = 2'd1;
              ALUop     = A_SLT;
            end
            F_JR:   muxPC = 2'd2;
            F_MFHI: begin
              regWrite  = 1'b1;
              muxWD3_en = 2'd2;
            end
            F_MFLO: begin
              regWrite  = 1'b1;
              muxWD3_en = 2'd3;
            end
            F_MULT:  multiplyEn = 1'b1;
            default: ;
          endcase
        end
        OP_LW: regWrite = 1'b1;
        OP_SW: dm_we    = 1'b1;
        OP_BEQ: begin
          muxB_en = 2'd1;
          ALUop   = A_SUB;
          muxPC   = zero ? 2'd3 : 2'd0;
        end
        OP_BNE: begin
          muxB_en = 2'd1;
          ALUop   = A_SUB;
          muxPC   = zero ? 2'd0 : 2'd3;
        end
        OP_ADDI: begin
          regWrite  = 1'b1;
          muxWD3_en = 2'd1;
          ALUop     = A_ADD;
        end
        OP_XORI: begin
          regWrite  = 1'b1;
          muxWD3_en = 2'd1;
          ALUop     = A_XOR;
        end
        OP_J: muxPC = 2'd1;
        OP_JAL: begin
          muxPC             = 2'd1;
          regWrite          = 1'b1;
          muxA_en           = 1'b1;
          muxB_en           = 2'd2;
          regWriteAddSelect = 2'd1;
          muxWD3_en         = 2'd1;
        end
        OP_LWC1: begin
          floatWriteAddrSelect = 1'b1;
          floatRegWrite        = 1'b1;
        end
        OP_SWC1: begin
          dm_we        = 1'b1;
          dmDataSelect = 1'b1;
        end
        OP_FR: begin
          fpu_start = 1'b1;
          ALUop     = w_fpu_op;
        end
        default: ;
      endcase
    end else if (r_state == S_FWB) begin
      floatRegWrite     = 1'b1;
      floatRWSelect     = 1'b1;
      regWriteAddSelect = 2'd3;
      ALUop             = w_fpu_op;
    end
  end

endmodule

// File: tb/tb_multicycle_decoder.sv
// Directed bench for multicycle_decoder: handshake, decode, MULT/FPU
// stalls, trap behaviour and reset recovery.
module tb_multicycle_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [5:0] opcode;
  logic [5:0] functcode;
  logic [4:0] fmt;
  logic       zero;
  logic       fpu_done;
  logic       fpu_start;
  logic       stall;
  logic       illegal;
  logic       regWrite;
  logic       muxA_en;
  logic       dm_we;
  logic       multiplyEn;
  logic       dmDataSelect;
  logic [1:0] muxB_en;
  logic [1:0] regWriteAddSelect;
  logic [1:0] muxPC;
  logic [1:0] muxWD3_en;
  logic [2:0] ALUop;
  logic       floatWriteAddrSelect;
  logic       floatRegWrite;
  logic       floatRWSelect;

  int npass = 0;
  int nchk  = 0;

  multicycle_decoder #(.MULT_CYCLES(4), .ALUOP_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .opcode(opcode),
    .functcode(functcode),
    .fmt(fmt),
    .zero(zero),
    .fpu_done(fpu_done),
    .fpu_start(fpu_start),
    .stall(stall),
    .illegal(illegal),
    .regWrite(regWrite),
    .muxA_en(muxA_en),
    .dm_we(dm_we),
    .multiplyEn(multiplyEn),
    .dmDataSelect(dmDataSelect),
    .muxB_en(muxB_en),
    .regWriteAddSelect(regWriteAddSelect),
    .muxPC(muxPC),
    .muxWD3_en(muxWD3_en),
    .ALUop(ALUop),
    .floatWriteAddrSelect(floatWriteAddrSelect),
    .floatRegWrite(floatRegWrite),
    .floatRWSelect(floatRWSelect)
  );

  always #5 clk = ~clk;

  logic [21:0] w_all;
  assign w_all = {fpu_start, stall, illegal, regWrite, muxA_en, dm_we,
                  multiplyEn, dmDataSelect, muxB_en, regWriteAddSelect,
                  muxPC, muxWD3_en, ALUop, floatWriteAddrSelect,
                  floatRegWrite, floatRWSelect};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [5:0] op, input logic [5:0] fn,
                     input logic [4:0] fm);
    instr_valid = 1'b1;
    opcode      = op;
    functcode   = fn;
    fmt         = fm;
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    reset       = 1'b1;
    tick();
    reset       = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; opcode = '0; functcode = '0;
    fmt = '0; zero = 1'b0; fpu_done = 1'b0;
    tick();
    do_reset();
    chk("rst_ready", 32'(instr_ready), 1);
    chk("rst_outs", 32'(w_all), 0);

    // ADD, SUB, XORI back to back
    put(6'h00, 6'h20, 5'h0); #1;
    tick();
    put(6'h00, 6'h22, 5'h0); #1;
    chk("add_alu", 32'(ALUop), 0);
    chk("add_rw", 32'(regWrite), 1);
    chk("add_rdy", 32'(instr_ready), 1);
    chk("add_stall", 32'(stall), 0);
    tick();
    put(6'h0e, 6'h00, 5'h0); #1;
    chk("sub_alu", 32'(ALUop), 1);
    chk("sub_rw", 32'(regWrite), 1);
    chk("sub_rdy", 32'(instr_ready), 1);
    tick();
    instr_valid = 1'b0; #1;
    chk("xori_alu", 32'(ALUop), 2);
    chk("xori_rw", 32'(regWrite), 1);
    chk("xori_stall", 32'(stall), 0);
    tick();

    // BEQ / BNE with zero=1, then JAL
    zero = 1'b1;
    put(6'h04, 6'h00, 5'h0); tick(); instr_valid = 1'b0; #1;
    chk("beq_pc", 32'(muxPC), 3);
    chk("beq_alu", 32'(ALUop), 1);
    tick();
    put(6'h05, 6'h00, 5'h0); tick(); instr_valid = 1'b0; #1;
    chk("bne_pc", 32'(muxPC), 0);
    tick();
    zero = 1'b0;
    put(6'h03, 6'h00, 5'h0); tick(); instr_valid = 1'b0; #1;
    chk("jal_pc", 32'(muxPC), 1);
    chk("jal_a", 32'(muxA_en), 1);
    chk("jal_b", 32'(muxB_en), 2);
    chk("jal_wa", 32'(regWriteAddSelect), 1);
    tick();

    // MULT, 4 cycles, then held MFLO
    put(6'h00, 6'h18, 5'h0); tick();
    put(6'h00, 6'h12, 5'h0); #1;
    chk("mul_en", 32'(multiplyEn), 1);
    chk("mul_rdy0", 32'(instr_ready), 0);
    chk("mul_st0", 32'(stall), 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("mul_stall%0d", i), 32'(stall), 1);
      chk($sformatf("mul_rdy%0d", i), 32'(instr_ready), 0);
      chk($sformatf("mul_en%0d", i), 32'(multiplyEn), 0);
    end
    tick();
    chk("mul_idle_st", 32'(stall), 0);
    chk("mul_idle_rdy", 32'(instr_ready), 1);
    tick(); instr_valid = 1'b0; #1;
    chk("mflo_wd3", 32'(muxWD3_en), 3);
    chk("mflo_rw", 32'(regWrite), 1);
    tick();

    // FR add.s, fpu_done 5 cycles after fpu_start
    put(6'h11, 6'h00, 5'h10); tick();
    instr_valid = 1'b0; fpu_done = 1'b1; #1;
    chk("fr_start", 32'(fpu_start), 1);
    chk("fr_rw", 32'(regWrite | floatRegWrite), 0);
    chk("fr_alu", 32'(ALUop), 0);
    tick(); fpu_done = 1'b0; #1;
    chk("fr_wait_st", 32'(stall), 1);
    chk("fr_wait_start", 32'(fpu_start), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fr_hold%0d", i), 32'(stall), 1);
      chk($sformatf("fr_nofwb%0d", i), 32'(floatRegWrite), 0);
    end
    tick(); fpu_done = 1'b1; #1;
    chk("fr_wait5", 32'(stall), 1);
    tick(); fpu_done = 1'b0; #1;
    chk("fwb_frw", 32'(floatRegWrite), 1);
    chk("fwb_sel", 32'(floatRWSelect), 1);
    chk("fwb_wa", 32'(regWriteAddSelect), 3);
    chk("fwb_st", 32'(stall), 1);
    tick();
    chk("fwb_idle_rdy", 32'(instr_ready), 1);
    chk("fwb_idle_outs", 32'(w_all), 0);
    fpu_done = 1'b1; tick(); fpu_done = 1'b0; #1;
    chk("stray_rdy", 32'(instr_ready), 1);
    chk("stray_outs", 32'(w_all), 0);

    // FR with double fmt traps
    put(6'h11, 6'h00, 5'h11); tick(); instr_valid = 1'b0; #1;
    chk("frd_nostart", 32'(fpu_start), 0);
    tick();
    chk("frd_ill", 32'(illegal), 1);
    chk("frd_rdy", 32'(instr_ready), 0);
    chk("frd_st", 32'(stall), 1);
    put(6'h00, 6'h20, 5'h0); tick(); tick(); #1;
    chk("frd_sticky", 32'(illegal), 1);
    chk("frd_norw", 32'(regWrite), 0);
    do_reset();
    chk("frd_clr", 32'(illegal), 0);
    chk("frd_clr_rdy", 32'(instr_ready), 1);

    // Unknown opcode traps
    put(6'h3f, 6'h00, 5'h0); tick(); instr_valid = 1'b0; tick();
    chk("op3f_ill", 32'(illegal), 1);
    chk("op3f_rdy", 32'(instr_ready), 0);
    do_reset();
    chk("op3f_clr", 32'(illegal), 0);

    // Reset during MWAIT
    put(6'h00, 6'h18, 5'h0); tick(); instr_valid = 1'b0; tick();
    chk("mw_pre", 32'(stall), 1);
    do_reset();
    chk("mw_rst_outs", 32'(w_all), 0);
    chk("mw_rst_rdy", 32'(instr_ready), 1);
    put(6'h00, 6'h20, 5'h0); tick(); instr_valid = 1'b0; #1;
    chk("mw_add_rw", 32'(regWrite), 1);
    chk("mw_add_st", 32'(stall), 0);
    tick();

    // Reset during FWAIT
    put(6'h11, 6'h01, 5'h10); tick(); instr_valid = 1'b0; #1;
    chk("fw_sub_alu", 32'(ALUop), 1);
    tick();
    chk("fw_pre", 32'(stall), 1);
    do_reset();
    chk("fw_rst_outs", 32'(w_all), 0);
    chk("fw_rst_rdy", 32'(instr_ready), 1);
    fpu_done = 1'b1; tick(); fpu_done = 1'b0; #1;
    chk("fw_rst_nofwb", 32'(w_all), 0);
    put(6'h00, 6'h20, 5'h0); tick(); instr_valid = 1'b0; #1;
    chk("fw_add_rw", 32'(regWrite), 1);
    chk("fw_add_nostart", 32'(fpu_start), 0);
    tick();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
